// File: rtl/alu_rf_pipe_if.sv
// alu_rf_pipe_if: issue and result bus between decode and the ALU/register-file pipeline.
interface alu_rf_pipe_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic              in_valid_i;
    logic [3:0]        op_i;
    logic [ADDR_W-1:0] ra1_i;
    logic [ADDR_W-1:0] ra2_i;
    logic [ADDR_W-1:0] wa_i;
    logic              we_i;
    logic              use_imm_i;
    logic [WIDTH-1:0]  imm_i;
    logic              out_valid_o;
    logic [WIDTH-1:0]  result_o;
    logic [4:0]        flags_o;
    modport master (
        output in_valid_i, op_i, ra1_i, ra2_i, wa_i, we_i, use_imm_i, imm_i,
        input  out_valid_o, result_o, flags_o
    );
    modport slave (
        input  in_valid_i, op_i, ra1_i, ra2_i, wa_i, we_i, use_imm_i, imm_i,
        output out_valid_o, result_o, flags_o
    );
endinterface

// File: rtl/alu_rf_pipe.sv
// alu_rf_pipe: register file + one registered execute stage with flags {N,Z,F,L,C}.
// Define ALU_RF_BYPASS_EN to forward the E-stage result to a same-cycle dependent issue.
module alu_rf_pipe #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           reset,
    alu_rf_pipe_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam int SH    = $clog2(WIDTH);
    localparam int M     = WIDTH - 1;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_LSH = 4'd6;
    localparam logic [3:0] OP_RSH = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;

    logic [WIDTH-1:0]  rf_q [NREGS];
    logic              e_valid_q;
    logic [3:0]        e_op_q;
    logic [WIDTH-1:0]  e_a_q;
    logic [WIDTH-1:0]  e_b_q;
    logic [ADDR_W-1:0] e_wa_q;
    logic              e_we_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  result_q;
    logic [4:0]        flags_q;

    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic [SH-1:0]     shamt;
    logic [WIDTH-1:0]  alu_res;
    logic [4:0]        flags_d;
    logic [WIDTH-1:0]  op_a_d;
    logic [WIDTH-1:0]  op_b_d;
    logic              is_add;
    logic              arith;
    logic              e_wr;

    assign sum    = {1'b0, e_a_q} + {1'b0, e_b_q};
    assign diff   = {1'b0, e_a_q} - {1'b0, e_b_q};
    assign shamt  = e_b_q[SH-1:0];
    assign is_add = e_op_q == OP_ADD;
    assign arith  = is_add || e_op_q == OP_SUB || e_op_q == OP_CMP;
    assign e_wr   = e_valid_q && e_we_q && e_op_q <= OP_MOV;

    always_comb begin
        case (e_op_q)
            OP_ADD:          alu_res = sum[M:0];
            OP_SUB, OP_CMP:  alu_res = diff[M:0];
            OP_AND:          alu_res = e_a_q & e_b_q;
            OP_OR:           alu_res = e_a_q | e_b_q;
            OP_XOR:          alu_res = e_a_q ^ e_b_q;
            OP_NOT:          alu_res = ~e_a_q;
            OP_LSH:          alu_res = e_a_q << shamt;
            OP_RSH:          alu_res = e_a_q >> shamt;
            OP_ASR:          alu_res = WIDTH'($signed(e_a_q) >>> shamt);
            OP_MOV:          alu_res = e_b_q;
            default:         alu_res = '0;
        endcase
    end

    // C/L/F/N follow arithmetic ops only; Z tracks every defined op, reserved ops hold all.
    assign flags_d[0] = arith ? (is_add ? sum[WIDTH] : diff[WIDTH]) : flags_q[0];
    assign flags_d[1] = arith ? (!is_add && diff[WIDTH]) : flags_q[1];
    assign flags_d[2] = arith ? (is_add ? (~(e_a_q[M] ^ e_b_q[M]) & (sum[M] ^ e_a_q[M]))
                                        : ((e_a_q[M] ^ e_b_q[M]) & (diff[M] ^ e_a_q[M])))
                              : flags_q[2];
    assign flags_d[3] = e_op_q <= OP_CMP ? ~|alu_res : flags_q[3];
    assign flags_d[4] = arith ? (!is_add && $signed(e_a_q) < $signed(e_b_q)) : flags_q[4];

`ifdef ALU_RF_BYPASS_EN
    assign op_a_d = (e_wr && e_wa_q == bus.ra1_i) ? alu_res : rf_q[bus.ra1_i];
    assign op_b_d = bus.use_imm_i ? bus.imm_i
                  : (e_wr && e_wa_q == bus.ra2_i) ? alu_res : rf_q[bus.ra2_i];
`else
    assign op_a_d = rf_q[bus.ra1_i];
    assign op_b_d = bus.use_imm_i ? bus.imm_i : rf_q[bus.ra2_i];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            e_valid_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            e_valid_q   <= bus.in_valid_i;
            out_valid_q <= e_valid_q;
            if (bus.in_valid_i) begin
                e_op_q <= bus.op_i;
                e_a_q  <= op_a_d;
                e_b_q  <= op_b_d;
                e_wa_q <= bus.wa_i;
                e_we_q <= bus.we_i;
            end
            if (e_valid_q) begin
                result_q <= alu_res;
                flags_q  <= flags_d;
            end
            if (e_wr) rf_q[e_wa_q] <= alu_res;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.flags_o     = flags_q;
endmodule

// File: tb/tb_alu_rf_pipe.sv
// tb_alu_rf_pipe: directed test-plan steps then random ops, checked against an arithmetic reference model.
module tb_alu_rf_pipe;
    localparam int W  = 16;
    localparam int AW = 4;
    localparam int N  = 2 ** AW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_rf_pipe_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
    alu_rf_pipe #(.WIDTH(W), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [W-1:0]  rf_m [N];
    logic          vld_m = 1'b0;
    logic [W-1:0]  res_m = '0;
    logic [4:0]    fl_m  = '0;
    logic          p_v = 1'b0, p_we = 1'b0;
    logic [3:0]    p_op = '0;
    logic [W-1:0]  p_a = '0, p_b = '0;
    logic [AW-1:0] p_wa = '0;
    int            cmp_n = 0, err_n = 0;

    function automatic logic [W+4:0] alu_m(input logic [3:0] o, input logic [W-1:0] a, b, input logic [4:0] f);
        longint ua = a, ub = b, sa = $signed(a), sb = $signed(b);
        longint lo = -(longint'(1) << (W - 1)), hi = (longint'(1) << (W - 1)) - 1;
        int sh = int'(b % W);
        logic [W-1:0] r;
        logic [4:0] nf = f;
        case (o)
            0: begin r = W'(ua + ub); nf[0] = (ua + ub) >= (longint'(1) << W); nf[1] = 1'b0; nf[4] = 1'b0;
                     nf[2] = (sa + sb < lo) || (sa + sb > hi); end
            1, 10: begin r = W'(ua - ub); nf[0] = ua < ub; nf[1] = ua < ub; nf[4] = sa < sb;
                     nf[2] = (sa - sb < lo) || (sa - sb > hi); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~a;
            6: r = W'(ua << sh);
            7: r = W'(ua >> sh);
            8: r = W'(sa >>> sh);
            9: r = b;
            default: r = '0;
        endcase
        if (o <= 10) nf[3] = (r == 0);
        return {nf, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic iv, input logic [3:0] o, input logic [AW-1:0] r1, r2, w,
                        input logic we, ui, input logic [W-1:0] im);
        logic [W+4:0] pr;
        logic [W-1:0] a, b;
        bus.in_valid_i = iv; bus.op_i = o; bus.ra1_i = r1; bus.ra2_i = r2;
        bus.wa_i = w; bus.we_i = we; bus.use_imm_i = ui; bus.imm_i = im;
        pr = p_v ? alu_m(p_op, p_a, p_b, fl_m) : '0;
        a = rf_m[r1];
        b = ui ? im : rf_m[r2];
`ifdef ALU_RF_BYPASS_EN
        if (p_v && p_we && p_op <= 9) begin
            if (p_wa == r1) a = pr[W-1:0];
            if (!ui && p_wa == r2) b = pr[W-1:0];
        end
`endif
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < N; i++) rf_m[i] = '0;
            vld_m = 1'b0; res_m = '0; fl_m = '0; p_v = 1'b0;
        end else begin
            vld_m = p_v;
            if (p_v) begin
                res_m = pr[W-1:0];
                fl_m  = pr[W+4:W];
                if (p_we && p_op <= 9) rf_m[p_wa] = res_m;
            end
            p_v = iv; p_op = o; p_a = a; p_b = b; p_wa = w; p_we = we;
        end
        chk("out_valid", 32'(bus.out_valid_o), 32'(vld_m));
        chk("result", 32'(bus.result_o), 32'(res_m));
        chk("flags", 32'(bus.flags_o), 32'(fl_m));
    endtask

    task automatic idle();
        tick(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    logic [4:0] saved_fl;

    initial begin
        for (int i = 0; i < N; i++) rf_m[i] = '0;
        do_reset();
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_flags", 32'(bus.flags_o), 32'd0);
        tick(1'b1, 4'd9, '0, '0, '0, 1'b0, 1'b0, '0);
        chk("first_op_lat1", 32'(bus.out_valid_o), 32'd0);
        for (int i = 1; i < N; i++) begin
            tick(1'b1, 4'd9, '0, AW'(i), '0, 1'b0, 1'b0, '0);
            chk("rf_reset_zero", 32'(bus.result_o), 32'd0);
        end
        idle();
        idle();
        // MOV 0x7FFF->R1, MOV 1->R2, ADD R1,R2->R3
        tick(1'b1, 4'd9, '0, '0, 4'd1, 1'b1, 1'b1, 16'h7FFF);
        tick(1'b1, 4'd9, '0, '0, 4'd2, 1'b1, 1'b1, 16'h0001);
        idle();
        tick(1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, '0);
        idle();
        chk("add_result", 32'(bus.result_o), 32'h8000);
        chk("add_flags", 32'(bus.flags_o), 32'b00100);
        tick(1'b1, 4'd9, '0, 4'd3, '0, 1'b0, 1'b0, '0);
        idle();
        chk("r3_read", 32'(bus.result_o), 32'h8000);
        // CMP R2,R1 with we=1 must not write R2
        tick(1'b1, 4'd10, 4'd2, 4'd1, 4'd2, 1'b1, 1'b0, '0);
        idle();
        chk("cmp_result", 32'(bus.result_o), 32'h8002);
        chk("cmp_flags", 32'(bus.flags_o), 32'b10011);
        tick(1'b1, 4'd9, '0, 4'd2, '0, 1'b0, 1'b0, '0);
        idle();
        chk("r2_after_cmp", 32'(bus.result_o), 32'h0001);
        // dependent back-to-back: MOV 5->R4 then ADD R4,R4->R5
        tick(1'b1, 4'd9, '0, '0, 4'd4, 1'b1, 1'b1, 16'd5);
        tick(1'b1, 4'd0, 4'd4, 4'd4, 4'd5, 1'b1, 1'b0, '0);
        idle();
        idle();
        tick(1'b1, 4'd9, '0, 4'd5, '0, 1'b0, 1'b0, '0);
        idle();
`ifdef ALU_RF_BYPASS_EN
        chk("r5_bypass", 32'(bus.result_o), 32'd10);
`else
        chk("r5_stale", 32'(bus.result_o), 32'd0);
`endif
        // shifts: flags C/L/F/N must hold
        tick(1'b1, 4'd9, '0, '0, 4'd6, 1'b1, 1'b1, 16'h8000);
        tick(1'b1, 4'd9, '0, '0, 4'd7, 1'b1, 1'b1, 16'h0001);
        idle();
        saved_fl = bus.flags_o;
        tick(1'b1, 4'd8, 4'd6, '0, '0, 1'b0, 1'b1, 16'd15);
        tick(1'b1, 4'd7, 4'd6, '0, '0, 1'b0, 1'b1, 16'd15);
        chk("asr_result", 32'(bus.result_o), 32'hFFFF);
        chk("asr_flags_held", 32'(bus.flags_o & 5'b10111), 32'(saved_fl & 5'b10111));
        tick(1'b1, 4'd6, 4'd7, '0, '0, 1'b0, 1'b1, 16'd16);
        chk("rsh_result", 32'(bus.result_o), 32'h0001);
        chk("rsh_flags_held", 32'(bus.flags_o & 5'b10111), 32'(saved_fl & 5'b10111));
        idle();
        chk("lsh_result", 32'(bus.result_o), 32'h0001);
        chk("lsh_flags_held", 32'(bus.flags_o & 5'b10111), 32'(saved_fl & 5'b10111));
        // reset while an ADD sits in E
        tick(1'b1, 4'd0, 4'd1, 4'd2, 4'd8, 1'b1, 1'b0, '0);
        do_reset();
        chk("rst_kill_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_kill_result", 32'(bus.result_o), 32'd0);
        tick(1'b1, 4'd12, 4'd1, 4'd2, 4'd9, 1'b1, 1'b0, '0);
        idle();
        chk("rsvd_valid", 32'(bus.out_valid_o), 32'd1);
        chk("rsvd_result", 32'(bus.result_o), 32'd0);
        chk("rsvd_flags", 32'(bus.flags_o), 32'd0);
        tick(1'b1, 4'd9, '0, 4'd8, '0, 1'b0, 1'b0, '0);
        idle();
        chk("r8_no_write", 32'(bus.result_o), 32'd0);
        // random traffic
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 79) == 0);
            tick(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), AW'($urandom), AW'($urandom),
                 AW'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
        end
        reset = 1'b0;
        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule

// File: doc/alu_rf_pipe.md
Name: alu_rf_pipe

Overview:
- Parametrised successor to the team's single-cycle ALU + register file pair.
- Register file has configurable width and depth, a separate write address and an immediate operand path.
- One registered execute stage, a persistent flag register, and optional same-cycle operand bypass.
- Sits between instruction decode and the rest of the datapath; decode issues one operation per cycle with in_valid.

Parameters:
WIDTH, 16, datapath and register width in bits (>= 8, power of two)
ADDR_W, 4, register address width; register count NREGS = 2**ADDR_W

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation issue strobe, one op per cycle, no backpressure
op  input  4  opcode (see Behaviour)
ra1  input  ADDR_W  register address of operand A
ra2  input  ADDR_W  register address of operand B
wa  input  ADDR_W  write-back register address
we  input  1  write-back enable for this op
use_imm  input  1  1: operand B = imm; 0: operand B = RF[ra2]
imm  input  WIDTH  immediate operand
out_valid  output  1  result/flags valid for the op issued two cycles earlier
result  output  WIDTH  registered ALU result
flags  output  5  registered flag register {N,Z,F,L,C}, bit0 = C

Behaviour:
- Reset (reset=1 at a clock edge):
  - All NREGS registers become 0; E-stage valid becomes 0.
  - out_valid=0, result=0, flags=0.
  - Reset overrides any in-flight op; that op never writes back.
- Issue, cycle T, with in_valid=1:
  - A = RF[ra1]; B = use_imm ? imm : RF[ra2].
  - A, B, op, wa and we are captured into the E stage at the end of T.
- Execute, cycle T+1:
  - The ALU computes combinationally from the E stage.
  - At the end of T+1: result and flags are registered, out_valid is set to 1, and RF[wa] is written if we=1 and the op writes.
  - out_valid is high during T+2, so latency issue-to-output is 2 clocks.
  - If no op is in E, out_valid goes to 0 and result/flags hold their values.
- Back-to-back issue every cycle is supported; throughput is 1 op/clock.
- Opcodes (arithmetic mod 2**WIDTH):
  - 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A.
  - 6 LSH A<<B[log2(WIDTH)-1:0]; 7 RSH logical; 8 ASR arithmetic; 9 MOV B.
  - 10 CMP: computes A-B and updates flags; never writes the RF regardless of we; result output = A-B.
  - 11-15 reserved: result=0, no RF write, flags held, out_valid still asserted.
- Flags:
  - C: carry-out for ADD, borrow for SUB/CMP.
  - L: unsigned A<B (SUB/CMP).
  - F: signed overflow (ADD/SUB/CMP).
  - Z: result==0.
  - N: signed A<B (SUB/CMP).
  - C, L, F, N update only on ADD/SUB/CMP and hold on all other ops; ADD clears L and N.
  - Z updates on every non-reserved op.
- Same-address read/write in one cycle (issue reads register X while E stage writes X): governed by Optional Feature.
- Write to wa while also reading wa as a source is legal; the old value is the operand.

Optional Feature:
- Macro: ALU_RF_BYPASS_EN.
- Defined: when E valid & E.we & op writes & E.wa == ra1 (and/or ra2 with use_imm=0), the issuing op receives the E-stage ALU result instead of the RF value. Dependent ops can issue back-to-back.
- Undefined: no bypass; the RF read returns the pre-write value. Decode must insert one idle cycle between dependent ops. The bench checks that the stale value is returned.

Test Plan:
- Reset, then read every register via MOV with use_imm=0 -> all results 0, flags 0, out_valid low until the first op plus 2 clocks.
- MOV imm 0x7FFF -> R1, MOV imm 0x0001 -> R2, idle, ADD R1,R2 -> R3 -> result 0x8000, F=1, C=0, Z=0, and R3 reads 0x8000.
- CMP R2,R1 (1 vs 0x7FFF) with we=1, wa=R2 -> L=1, N=1, C=1, R2 unchanged 0x0001.
- Back-to-back MOV imm 5 -> R4, then ADD R4,R4 -> R5 the next cycle -> with bypass R5=10; without bypass R5=2*old R4 (0).
- ASR of 0x8000 by imm 15 -> 0xFFFF; RSH same -> 0x0001; LSH 0x0001 by 16 (shift amount masked to 0) -> 0x0001. Flags C/L/F/N unchanged across all three.
- Assert reset in the cycle an ADD with we=1 sits in E -> no RF write, out_valid=0 and result=0 the next cycle; opcode 12 issued after reset -> result 0, flags held, out_valid=1.
